// File: rtl/ais_ise.sv
// ---------------------------------------------------------------------------
// ais_ise : multi-cycle AES inverse S-box ISE unit for the HOKSTER ALU (aluc).
//
// Computes InvSbox(a) = (InvAffine(a))^254 in GF(2^8) with one squarer and
// one multiplier, stepping through the exponent MSB first. The core is
// stalled through `w` while the exponentiation runs, so no 256-entry LUT is
// needed.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous active-high reset
//   start   in   1  ISE opcode selected, held by the core until w is low
//   a       in   8  operand byte (S-box output value to invert)
//   sr      in   8  status register in
//   sr_out  out  8  status register out, combinational pass-through of sr
//   result  out  8  InvSbox(a), registered, valid in DONE
//   w       out  1  stall request to the core
// ---------------------------------------------------------------------------
module ais_ise (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] sr,
   output logic [7:0] sr_out,
   output logic [7:0] result,
   output logic       w
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Exponent 254: x^254 == x^-1 for non-zero x, and 0 maps to 0.
   localparam logic [7:0] EXP = 8'hFE;

   state_t     state_q;
   logic [7:0] t_q;
   logic [7:0] acc_q;
   logic [7:0] result_q;
   logic [2:0] cnt_q;

   logic [7:0] t_d;
   logic [7:0] sq_acc;
   logic [7:0] mul_b;
   logic [7:0] acc_d;

   // Reduce a 15-bit carry-less product modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_reduce(input logic [14:0] p_in);
      logic [14:0] p;
      p = p_in;
      for (int unsigned k = 0; k < 7; k++) begin
         if (p[14-k]) begin
            p = p ^ (15'h11B << (6 - k));
         end
      end
      return p[7:0];
   endfunction

   // Squaring is linear in GF(2^8): spread the bits, then reduce.
   function automatic logic [7:0] gf_sq(input logic [7:0] x);
      logic [14:0] s;
      s = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         s[2*i] = x[i];
      end
      return gf_reduce(s);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (y[i]) begin
            p = p ^ ({7'b0, x} << i);
         end
      end
      return gf_reduce(p);
   endfunction

   always_comb begin
      // Inverse affine: rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05
      t_d    = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      sq_acc = gf_sq(acc_q);
      mul_b  = EXP[cnt_q] ? t_q : 8'h01;
      acc_d  = gf_mul(sq_acc, mul_b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         acc_q    <= 8'h01;
         cnt_q    <= 3'd7;
         t_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  t_q     <= t_d;
                  acc_q   <= 8'h01;
                  cnt_q   <= 3'd7;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  result_q <= acc_d;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               // start is ignored here; the core samples result this cycle.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign result = result_q;
   assign sr_out = sr;
   // Stall is dropped while rst is asserted so the core never waits on an
   // operation that is being aborted.
   assign w      = ~rst & ((state_q == CALC) | ((state_q == IDLE) & start));

endmodule

// File: tb/tb_ais_ise.sv
// ---------------------------------------------------------------------------
// tb_ais_ise : self-checking bench for ais_ise.
//
// The reference is the forward AES S-box built from first principles
// (brute-force GF(2^8) inverse plus the forward affine map); feeding a
// value Sbox(x) must return x. Handshake timing, result hold, reset abort
// and sr pass-through are checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_ais_ise;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] sr;
   logic [7:0] sr_out;
   logic [7:0] result;
   logic       w;

   int         n_cmp;
   int         n_err;
   logic [7:0] sbox [256];
   logic [7:0] prev_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ais_ise dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .sr     (sr),
      .sr_out (sr_out),
      .result (result),
      .w      (w)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Shift-and-add GF(2^8) multiply, xtime style.
   function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, xx, yy;
      p = 8'h00; xx = x; yy = y;
      while (yy != 8'h00) begin
         if (yy[0]) p = p ^ xx;
         xx = xx[7] ? ((xx << 1) ^ 8'h1B) : (xx << 1);
         yy = yy >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x] = b;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation starting in an IDLE cycle; returns one edge after
   // DONE (i.e. in the following IDLE cycle) with start still high.
   task automatic run_op(input logic [7:0] av, input logic [7:0] expv,
                         input bit chg_a, input bit fixed_sr);
      int stall;
      bit done;
      stall = 0;
      done  = 1'b0;
      start = 1'b1;
      a     = av;
      for (int c = 0; c < 16 && !done; c++) begin
         if (fixed_sr) sr = (c % 2 == 0) ? 8'hA5 : 8'h3C;
         else          sr = 8'($urandom);
         #4;
         chk("sr_out", sr_out, sr);
         if (!w) begin
            done = 1'b1;
         end else begin
            chk("result_hold", result, prev_res);
            stall++;
            tick();
            if (chg_a) a = 8'hFF;
         end
      end
      chk("stall_cycles", 8'(stall), 8'd9);
      if (!done) begin
         rst = 1'b1; start = 1'b0;
         tick();
         rst = 1'b0;
         prev_res = 8'h00;
      end else begin
         chk("result", result, expv);
         prev_res = expv;
         tick();
      end
   endtask

   task automatic idle_check();
      start = 1'b0;
      #4;
      chk("w_idle", {7'b0, w}, 8'h00);
      chk("result_keep", result, prev_res);
      tick();
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      prev_res = 8'h00;
      build_sbox();

      // Reset held for two edges with a pending start.
      rst = 1'b1; start = 1'b1; a = 8'h63; sr = 8'h5A;
      for (int c = 0; c < 2; c++) begin
         tick();
         sr = 8'($urandom);
         #4;
         chk("rst_w", {7'b0, w}, 8'h00);
         chk("rst_result", result, 8'h00);
         chk("rst_sr_out", sr_out, sr);
         #1;
      end
      rst = 1'b0; start = 1'b0;
      tick();
      idle_check();

      // Directed vectors.
      run_op(8'h63, 8'h00, 1'b0, 1'b0); idle_check();
      run_op(8'h7C, 8'h01, 1'b0, 1'b0); idle_check();
      run_op(8'h16, 8'hFF, 1'b0, 1'b0); idle_check();
      run_op(8'h00, 8'h52, 1'b0, 1'b0); idle_check();
      run_op(8'h52, 8'h48, 1'b0, 1'b1); idle_check();

      // Operand changes after the load cycle.
      run_op(8'hC5, 8'h07, 1'b1, 1'b0); idle_check();

      // Mid-operation reset at cycle N+4.
      start = 1'b1; a = 8'h7C;
      for (int c = 0; c < 4; c++) tick();
      rst = 1'b1; start = 1'b0;
      tick();
      rst = 1'b0;
      #4;
      chk("abort_w", {7'b0, w}, 8'h00);
      chk("abort_result", result, 8'h00);
      prev_res = 8'h00;
      tick();
      run_op(8'h7C, 8'h01, 1'b0, 1'b0); idle_check();

      // Exhaustive back-to-back sweep: InvSbox(Sbox(x)) == x.
      for (int x = 0; x < 256; x++) begin
         run_op(sbox[x], 8'(x), 1'b0, 1'b0);
      end
      idle_check();

      // Random operands with random idle gaps.
      for (int k = 0; k < 40; k++) begin
         logic [7:0] xr;
         xr = 8'($urandom);
         run_op(sbox[xr], xr, ($urandom_range(0, 3) == 0), 1'b0);
         for (int g = $urandom_range(0, 2); g > 0; g--) idle_check();
      end
      idle_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ais_ise.md
Name: ais_ise

Overview:
- Multi-cycle AES inverse S-box instruction-set extension for the HOKSTER ALU (aluc). It is the decryption-side counterpart of the forward S-box ISE.
- Computes InvSbox(a) = GF(2^8) inverse of InvAffine(a), using a sequential square-and-multiply exponentiation (x^254).
- Holds the core stalled through `w` while it computes, so a full 256-entry LUT is not needed.
- Sits beside the other aluc ISE units and uses the same a/sr/sr_out/result/w interface.

Parameters:
- None.

Ports:
- clk     input   1  system clock. Single clock domain; everything registers on the rising edge.
- rst     input   1  reset, synchronous and active-high.
- start   input   1  ISE opcode selected. Held high by the core until `w` is low.
- a       input   8  operand byte (S-box output value to invert).
- sr      input   8  status register in.
- sr_out  output  8  status register out. Pass-through of `sr`, combinational.
- result  output  8  InvSbox(a). Registered.
- w       output  1  wait/stall request to the core. Combinational from state and start.

Behaviour:
- States: IDLE, CALC, DONE. Internal registers:
  - t[7:0]: transformed operand.
  - acc[7:0]: exponentiation accumulator.
  - cnt[2:0]: bit index.
- Reset (rst=1 at a clock edge):
  - state=IDLE, result=0x00, acc=0x01, cnt=7, t=0x00.
  - `w` goes low once rst has taken effect.
  - Reset during CALC or DONE aborts the operation with no partial result.
- Inverse affine:
  - t = rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05.
- GF multiply:
  - Polynomial basis, reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  - One combinational multiplier; squaring is done with the same multiplier or a dedicated squarer.
- IDLE:
  - When start=1: t <= InvAffine(a), acc <= 0x01, cnt <= 7, next state CALC. `w` = 1 in this same cycle.
  - When start=0: remain in IDLE, `w` = 0.
- CALC (exponent 254 = 8'b1111_1110, processed MSB first):
  - acc <= sq(acc) * (E[cnt] ? t : 0x01), where E = 8'hFE.
  - cnt decrements each cycle.
  - When cnt==0: result <= the new acc value and the next state is DONE.
  - `w` = 1 throughout CALC.
- DONE:
  - `w` = 0. `result` is valid and stable; the core samples it this cycle.
  - Next state is IDLE unconditionally; `start` is ignored in DONE.
  - `result` holds its value until the next operation reaches DONE.
- Latency:
  - start first seen at cycle N.
  - `w` is high for cycles N through N+8 (9 cycles).
  - DONE at N+9: `w` low, `result` valid.
  - A back-to-back instruction may raise start at N+10 (IDLE).
- Zero handling:
  - a=0x63 gives t=0x00, and 0^254=0, so result=0x00. No special case is required.
- `a` may change after the IDLE load cycle without affecting the result, because `t` is latched.
- sr_out == sr in every cycle, including during reset. No status flags are modified.
- No X propagation:
  - All case statements are fully specified.
  - An illegal state encoding recovers to IDLE.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1, a=0x63 -> w=0, result=0x00, sr_out=sr throughout. After release, the operation starts on the next start=1 in IDLE.
- Basic vectors, one operation each, with the full handshake:
  - a=0x63 -> 0x00
  - a=0x7C -> 0x01
  - a=0x16 -> 0xFF
  - a=0x00 -> 0x52
  - a=0x52 -> 0x48
  - For each: w high for exactly 9 cycles starting the cycle start rises, result valid in the following cycle.
- Exhaustive sweep: all 256 values of `a`, back-to-back with start re-asserted in the cycle after DONE. Check result against an inverse S-box model; InvSbox(Sbox(x)) == x for every x.
- Operand change: issue a=0xC5, then change `a` to 0xFF from cycle N+1 onward -> result=0x07, unaffected by the change.
- Mid-operation reset: assert rst at cycle N+4 of an a=0x7C operation -> w=0 and result=0x00 after the reset edge. A fresh a=0x7C operation afterwards gives 0x01 with the nominal 9-cycle stall.
- sr pass-through: drive sr=0xA5, then 0x3C during CALC -> sr_out tracks sr in the same cycle. result and w are unaffected.
